// File: rtl/mutex_req_ctrl.sv
// Two-client front end for an asynchronous mutex: synchronised grants, four-phase request handshake, hold timeout.
// Optional sticky exclusion checker enabled by defining MUTEX_REQ_CTRL_EXCL_CHECK_EN.
module mutex_req_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic cli_req_a,
  input  logic cli_req_b,
  input  logic cli_done_a,
  input  logic cli_done_b,
  output logic cli_gnt_a,
  output logic cli_gnt_b,
  output logic r1,
  output logic r2,
  input  logic g1,
  input  logic g2,
  output logic timeout_a,
  output logic timeout_b,
  output logic excl_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, OWN = 2'd2, REL = 2'd3} state_t;

  logic [SYNC_STAGES-1:0] sync1_r, sync2_r;
  logic [1:0]             gs_s, req_s, done_s, gnt_s, r_s, to_s;
  logic [2:0]             settle_r;
  logic                   settled_s;

  // Grant synchronisers and post-reset settle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      settle_r <= 3'd0;
    end else begin
      sync1_r <= {sync1_r[SYNC_STAGES-2:0], g1};
      sync2_r <= {sync2_r[SYNC_STAGES-2:0], g2};
      if (!settled_s) settle_r <= settle_r + 3'd1;
      else            settle_r <= settle_r;
    end
  end

  // Requests are blocked until the synchronisers hold real grant samples, so a
  // grant still high across reset is seen before any new request is raised.
  assign settled_s = (settle_r == 3'(SYNC_STAGES));
  assign gs_s      = {sync2_r[SYNC_STAGES-1], sync1_r[SYNC_STAGES-1]};
  assign req_s     = {cli_req_b, cli_req_a};
  assign done_s    = {cli_done_b, cli_done_a};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_t     state_r;
    logic [7:0] cnt_r;
    logic       drop_r, gnt_r, r_r, to_r;

    // Per-channel handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_r <= IDLE;
        cnt_r   <= 8'd0;
        drop_r  <= 1'b0;
        gnt_r   <= 1'b0;
        r_r     <= 1'b0;
        to_r    <= 1'b0;
      end else begin
        to_r <= 1'b0;
        case (state_r)
          IDLE: begin
            if (settled_s && req_s[ch] && !gs_s[ch]) begin
              state_r <= REQ;
              r_r     <= 1'b1;
              drop_r  <= 1'b0;
            end else begin
              state_r <= IDLE;
            end
          end
          REQ: begin
            drop_r <= drop_r | !req_s[ch];
            if (gs_s[ch]) begin
              state_r <= OWN;
              gnt_r   <= !drop_r && req_s[ch];
              cnt_r   <= 8'd0;
            end else begin
              state_r <= REQ;
            end
          end
          OWN: begin
            // A withdrawn request or done wins over the timeout on the same cycle.
            if (drop_r || done_s[ch]) begin
              state_r <= REL;
              r_r     <= 1'b0;
              gnt_r   <= 1'b0;
            end else if (cnt_r >= 8'(MAX_HOLD - 1)) begin
              state_r <= REL;
              r_r     <= 1'b0;
              gnt_r   <= 1'b0;
              to_r    <= 1'b1;
              cnt_r   <= 8'(MAX_HOLD);
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
          REL: begin
            if (!gs_s[ch]) state_r <= IDLE;
            else           state_r <= REL;
          end
          default: begin
            state_r <= IDLE;
            r_r     <= 1'b0;
            gnt_r   <= 1'b0;
          end
        endcase
      end
    end

    assign gnt_s[ch] = gnt_r;
    assign r_s[ch]   = r_r;
    assign to_s[ch]  = to_r;
  end

  assign cli_gnt_a = gnt_s[0];
  assign cli_gnt_b = gnt_s[1];
  assign r1        = r_s[0];
  assign r2        = r_s[1];
  assign timeout_a = to_s[0];
  assign timeout_b = to_s[1];

`ifdef MUTEX_REQ_CTRL_EXCL_CHECK_EN
  logic excl_r;

  // Sticky flag for both clients owning the resource at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) excl_r <= 1'b0;
    else        excl_r <= excl_r | (gnt_s[0] & gnt_s[1]);
  end

  assign excl_err = excl_r;
`else
  assign excl_err = 1'b0;
`endif

endmodule

// File: tb/tb_mutex_req_ctrl.sv
// Self-checking bench for mutex_req_ctrl: bench acts as the mutex and predicts
// timing from the handshake rules (grant latency, hold length, timeout).
module tb_mutex_req_ctrl;
  localparam int SS = 2;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, done, g, gnt, r, to;
  logic       excl;
  int         n_assert = 0;
  int         n_fail   = 0;
  logic       exp_excl;

  mutex_req_ctrl #(.SYNC_STAGES(SS), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset),
    .cli_req_a(req[0]), .cli_req_b(req[1]),
    .cli_done_a(done[0]), .cli_done_b(done[1]),
    .cli_gnt_a(gnt[0]), .cli_gnt_b(gnt[1]),
    .r1(r[0]), .r2(r[1]),
    .g1(g[0]), .g2(g[1]),
    .timeout_a(to[0]), .timeout_b(to[1]),
    .excl_err(excl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One client transaction on channel ch; the bench plays the mutex.
  task automatic xact(input int ch, input int gdl, input bit use_done, input int d, input int rdl);
    int rel;
    bit exp_to;
    rel    = (use_done && d < MH) ? d : MH;
    exp_to = !(use_done && d <= MH);
    req[ch] = 1'b1;
    step();
    chk("r_rise", 32'(r[ch]), 32'd1);
    for (int k = 0; k < gdl; k++) begin
      step();
      chk("r_hold_req", 32'(r[ch]), 32'd1);
      chk("gnt_wait", 32'(gnt[ch]), 32'd0);
    end
    g[ch] = 1'b1;
    for (int k = 1; k <= SS; k++) begin
      step();
      chk("gnt_latency", 32'(gnt[ch]), 32'd0);
    end
    for (int k = 1; k <= rel; k++) begin
      step();
      chk("gnt_on", 32'(gnt[ch]), 32'd1);
      chk("r_on", 32'(r[ch]), 32'd1);
      chk("to_quiet", 32'(to[ch]), 32'd0);
      done[ch] = (use_done && k == d);
    end
    step();
    done[ch] = 1'b0;
    chk("gnt_off", 32'(gnt[ch]), 32'd0);
    chk("r_off", 32'(r[ch]), 32'd0);
    chk("timeout_pulse", 32'(to[ch]), 32'(exp_to));
    done[ch] = 1'b1;
    step();
    done[ch] = 1'b0;
    chk("timeout_one", 32'(to[ch]), 32'd0);
    chk("done_in_rel", 32'(gnt[ch]), 32'd0);
    for (int k = 0; k < rdl; k++) begin
      step();
      chk("no_rereq_rel", 32'(r[ch]), 32'd0);
    end
    g[ch]   = 1'b0;
    req[ch] = 1'b0;
    for (int k = 0; k < SS + 2; k++) step();
    chk("idle_r", 32'(r[ch]), 32'd0);
    chk("idle_excl", 32'(excl), 32'd0);
  endtask

  initial begin
`ifdef MUTEX_REQ_CTRL_EXCL_CHECK_EN
    exp_excl = 1'b1;
`else
    exp_excl = 1'b0;
`endif
    reset = 1'b0; req = 2'b00; done = 2'b00; g = 2'b00;
    repeat (3) step();
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_to", 32'(to), 32'd0);
    chk("rst_excl", 32'(excl), 32'd0);
    reset = 1'b1;
    repeat (5) step();

    // Directed: plain done, timeout, done on the timeout cycle.
    xact(0, 3, 1'b1, 2, 2);
    xact(0, 0, 1'b0, 0, 1);
    xact(0, 1, 1'b1, MH, 0);
    xact(1, 2, 1'b1, 1, 3);

    // Randomised transactions.
    for (int i = 0; i < 20; i++)
      xact(int'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
           int'($urandom_range(MH + 2, 1)), int'($urandom_range(3, 0)));

    // Contention: both request, mutex grants A then B.
    req = 2'b11;
    step();
    chk("both_req", 32'(r), 32'd3);
    g[0] = 1'b1;
    for (int k = 0; k <= SS; k++) step();
    chk("cont_gnt_a", 32'(gnt), 32'd1);
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    chk("cont_rel_a", 32'(gnt), 32'd0);
    chk("cont_r_b", 32'(r), 32'd2);
    g = 2'b10;
    req[0] = 1'b0;
    for (int k = 0; k <= SS; k++) step();
    chk("cont_gnt_b", 32'(gnt), 32'd2);
    chk("cont_excl", 32'(excl), 32'd0);
    done[1] = 1'b1;
    step();
    done[1] = 1'b0;
    chk("cont_rel_b", 32'(gnt), 32'd0);
    g = 2'b00; req = 2'b00;
    for (int k = 0; k < SS + 2; k++) step();

    // Reset while B owns; grant still high afterwards must block a new request.
    req[1] = 1'b1;
    step();
    g[1] = 1'b1;
    for (int k = 0; k <= SS; k++) step();
    chk("own_b", 32'(gnt[1]), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_r2", 32'(r[1]), 32'd0);
    chk("async_gnt_b", 32'(gnt[1]), 32'd0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rst_block_r2", 32'(r[1]), 32'd0);
    end
    g[1] = 1'b0;
    for (int k = 0; k < SS; k++) begin
      step();
      chk("rst_wait_r2", 32'(r[1]), 32'd0);
    end
    step();
    chk("rst_rereq_r2", 32'(r[1]), 32'd1);

    // Request withdrawn while waiting: completes without granting the client.
    req[1] = 1'b0;
    g[1]   = 1'b1;
    for (int k = 0; k < SS + 3; k++) begin
      step();
      chk("abandon_no_gnt", 32'(gnt[1]), 32'd0);
    end
    chk("abandon_r_off", 32'(r[1]), 32'd0);
    g[1] = 1'b0;
    for (int k = 0; k < SS + 2; k++) step();

    // Misbehaving mutex grants both: exclusion checker.
    req = 2'b11;
    step();
    g = 2'b11;
    for (int k = 0; k <= SS; k++) step();
    chk("dual_gnt", 32'(gnt), 32'd3);
    step();
    chk("excl_set", 32'(excl), 32'(exp_excl));
    done = 2'b11;
    step();
    done = 2'b00; g = 2'b00; req = 2'b00;
    for (int k = 0; k < SS + 3; k++) step();
    chk("excl_sticky", 32'(excl), 32'(exp_excl));
    reset = 1'b0;
    #1;
    chk("excl_clear", 32'(excl), 32'd0);
    step();
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
